// File: rtl/cpu_ext_loader_pkg.sv
// Shared types and constants for the external-port loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ext_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_I    = 3'd1,
        ST_LOAD_D    = 3'd2,
        ST_RUN       = 3'd3,
        ST_DUMP_RD   = 3'd4,
        ST_DUMP_WAIT = 3'd5,
        ST_DUMP_OUT  = 3'd6,
        ST_FIN       = 3'd7
    } state_e;

    // Byte distance between consecutive 32-bit words on the _ext buses.
    localparam int unsigned ADDR_STEP_DEF = 4;

    // Data-memory read data is valid this many cycles after ren_ext_2.
    localparam int unsigned RD_LAT = 1;

endpackage

// File: rtl/cpu_ext_loader_if.sv
// Bundles the input word stream, the dump stream and both CPU external memory ports.
// Latency: n/a (wires only).
// Backpressure: s_valid/s_ready and m_valid/m_ready handshakes; memory ports have none.
//   master : the loader (drives s_ready, m_*, addr/wen/ren/wdata on both ports)
//   slave  : the environment (stream source/sink and the CPU memories)
interface cpu_ext_loader_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic [31:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [31:0] wdata_ext_2;
    logic [31:0] rdata_ext_2;

    modport master (
        input  s_valid, s_data, m_ready, rdata_ext_2,
        output s_ready, m_valid, m_data,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport slave (
        output s_valid, s_data, m_ready, rdata_ext_2,
        input  s_ready, m_valid, m_data,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface

// File: rtl/cpu_ext_loader_ext_word_writer.sv
// Stream-to-memory-port converter: each accepted word becomes a one-cycle write at the next word address.
// Latency: write appears on the port one cycle after the accept; reads one cycle after rd_i.
// Backpressure: none of its own; the caller decides when a word is accepted (acc_i).
//   load_i/words_i : latch word count, clear address and word counters
//   acc_i/data_i   : a word accepted this cycle; last_o flags the final one
//   rd_i/rd_addr_i : one-cycle read request sharing the same address register
//   addr_o/wen_o/ren_o/wdata_o : registered memory port
module ext_word_writer #(
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] words_i,
    input  logic             acc_i,
    input  logic [31:0]      data_i,
    input  logic             rd_i,
    input  logic [31:0]      rd_addr_i,
    output logic             last_o,
    output logic [31:0]      addr_o,
    output logic             wen_o,
    output logic             ren_o,
    output logic [31:0]      wdata_o
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    // One extra bit so a full 2^CNT_W-1 count never wraps before it matches.
    logic [CNT_W:0]   cnt_q;
    logic [CNT_W-1:0] words_q;
    logic [31:0]      wptr_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             wen_q;
    logic             ren_q;

    assign last_o  = acc_i && ((cnt_q + 1'b1) == {1'b0, words_q});
    assign addr_o  = addr_q;
    assign wen_o   = wen_q;
    assign ren_o   = ren_q;
    assign wdata_o = wdata_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q   <= '0;
            words_q <= '0;
            wptr_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
        end else begin
            wen_q <= acc_i;
            ren_q <= rd_i;
            if (load_i) begin
                words_q <= words_i;
                cnt_q   <= '0;
                wptr_q  <= '0;
            end else if (acc_i) begin
                cnt_q   <= cnt_q + 1'b1;
                wptr_q  <= wptr_q + STEP;
                addr_q  <= wptr_q;
                wdata_q <= data_i;
            end
            if (rd_i) begin
                addr_q <= rd_addr_i;
            end
        end
    end

endmodule

// File: rtl/cpu_ext_loader.sv
// Host-side loader: fills imem and dmem from a word stream, runs the CPU for N cycles, streams a dmem region out.
// Latency: writes land one cycle after each accept; each dump word takes RD + RD_LAT wait cycles before m_valid.
// Backpressure: s_ready only in the load phases (stalls while s_valid low); dump word held until m_ready.
//   clk/arst_n              : clock, asynchronous active-low reset
//   start + command fields  : sampled only in IDLE
//   bus (master)            : input stream, dump stream, imem (_ext) and dmem (_ext_2) ports
//   cpu_enable/busy/done    : CPU run gate and status
module cpu_ext_loader
    import cpu_ext_loader_pkg::*;
#(
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned RUN_W     = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_words,
    input  logic [CNT_W-1:0] dmem_words,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [31:0]      dump_base,
    input  logic [CNT_W-1:0] dump_words,
    cpu_ext_loader_if.master bus,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done
);

    localparam logic [31:0] STEP      = 32'(ADDR_STEP);
    localparam logic [3:0]  WAIT_INIT = 4'(RD_LAT - 1);

    state_e           state_q;
    logic             s_ready_q;
    logic             m_valid_q;
    logic [31:0]      m_data_q;
    logic             cpu_enable_q;
    logic             busy_q;
    logic             done_q;
    logic [RUN_W-1:0] run_cnt_q;
    logic [CNT_W-1:0] dmem_words_q;
    logic [CNT_W-1:0] dump_words_q;
    logic [31:0]      dump_addr_q;
    logic [CNT_W:0]   dump_cnt_q;
    logic [3:0]       wait_cnt_q;

    logic        load_cmd;
    logic        acc_i;
    logic        acc_d;
    logic        last_i;
    logic        last_d;
    logic        dump_last;
    logic        rd_go;
    logic [31:0] rd_addr_d;

    assign load_cmd  = (state_q == ST_IDLE) && start;
    assign acc_i     = (state_q == ST_LOAD_I) && s_ready_q && bus.s_valid;
    assign acc_d     = (state_q == ST_LOAD_D) && s_ready_q && bus.s_valid;
    assign dump_last = (dump_cnt_q + 1'b1) == {1'b0, dump_words_q};

    // The read request is issued on the edge that enters DUMP_RD, so ren_ext_2
    // and its address are registered outputs during the RD cycle itself.
    assign rd_go = ((state_q == ST_RUN) && (run_cnt_q == '0) && (dump_words_q != '0)) ||
                   ((state_q == ST_DUMP_OUT) && bus.m_ready && !dump_last);
    assign rd_addr_d = (state_q == ST_DUMP_OUT) ? dump_addr_q + STEP : dump_addr_q;

    ext_word_writer #(.CNT_W(CNT_W), .ADDR_STEP(ADDR_STEP)) u_imem_wr (
        .clk       (clk),
        .arst_n    (arst_n),
        .load_i    (load_cmd),
        .words_i   (imem_words),
        .acc_i     (acc_i),
        .data_i    (bus.s_data),
        .rd_i      (1'b0),
        .rd_addr_i (32'h0),
        .last_o    (last_i),
        .addr_o    (bus.addr_ext),
        .wen_o     (bus.wen_ext),
        .ren_o     (bus.ren_ext),
        .wdata_o   (bus.wdata_ext)
    );

    ext_word_writer #(.CNT_W(CNT_W), .ADDR_STEP(ADDR_STEP)) u_dmem_wr (
        .clk       (clk),
        .arst_n    (arst_n),
        .load_i    (load_cmd),
        .words_i   (dmem_words),
        .acc_i     (acc_d),
        .data_i    (bus.s_data),
        .rd_i      (rd_go),
        .rd_addr_i (rd_addr_d),
        .last_o    (last_d),
        .addr_o    (bus.addr_ext_2),
        .wen_o     (bus.wen_ext_2),
        .ren_o     (bus.ren_ext_2),
        .wdata_o   (bus.wdata_ext_2)
    );

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign cpu_enable  = cpu_enable_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // RUN spends its first cycle with enable low so the final load write
    // (issued the cycle after the last accept) never coincides with enable.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            run_cnt_q    <= '0;
            dmem_words_q <= '0;
            dump_words_q <= '0;
            dump_addr_q  <= '0;
            dump_cnt_q   <= '0;
            wait_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dmem_words_q <= dmem_words;
                        dump_words_q <= dump_words;
                        run_cnt_q    <= run_cycles;
                        dump_addr_q  <= dump_base;
                        dump_cnt_q   <= '0;
                        busy_q       <= 1'b1;
                        if (imem_words != '0) begin
                            state_q   <= ST_LOAD_I;
                            s_ready_q <= 1'b1;
                        end else if (dmem_words != '0) begin
                            state_q   <= ST_LOAD_D;
                            s_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_LOAD_I: begin
                    if (last_i) begin
                        if (dmem_words_q != '0) begin
                            state_q <= ST_LOAD_D;
                        end else begin
                            state_q   <= ST_RUN;
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                ST_LOAD_D: begin
                    if (last_d) begin
                        state_q   <= ST_RUN;
                        s_ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (run_cnt_q == '0) begin
                        cpu_enable_q <= 1'b0;
                        if (dump_words_q != '0) begin
                            state_q <= ST_DUMP_RD;
                        end else begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cpu_enable_q <= 1'b1;
                        run_cnt_q    <= run_cnt_q - 1'b1;
                    end
                end
                ST_DUMP_RD: begin
                    state_q    <= ST_DUMP_WAIT;
                    wait_cnt_q <= WAIT_INIT;
                end
                ST_DUMP_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        m_data_q  <= bus.rdata_ext_2;
                        m_valid_q <= 1'b1;
                        state_q   <= ST_DUMP_OUT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                ST_DUMP_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q   <= 1'b0;
                        dump_cnt_q  <= dump_cnt_q + 1'b1;
                        dump_addr_q <= dump_addr_q + STEP;
                        if (dump_last) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DUMP_RD;
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
